// File: rtl/gate_vector_checker_if.sv
// -----------------------------------------------------------------------------
// gate_vector_checker_if
//   Bundles the run-control and gate-stimulus/response signals between a test
//   controller, the gate_vector_checker and the gate block under test.
//
//   start           controller -> checker   run request
//   vec_out         checker -> gate block   applied input vector {a,b,c,d,...}
//   x_in/y_in/z_in  gate block -> checker   AND / OR / NOR outputs
//   busy, done, pass, err_count, vec_idx, first_fail_vec
//                   checker -> controller   run status and results
//
//   slave  : the checker's view
//   master : the controller / environment view
// -----------------------------------------------------------------------------
interface gate_vector_checker_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            x_in;
  logic            y_in;
  logic            z_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [7:0]      err_count;
  logic [7:0]      vec_idx;
  logic [N_IN-1:0] first_fail_vec;

  modport slave (
    input  start, x_in, y_in, z_in,
    output vec_out, busy, done, pass, err_count, vec_idx, first_fail_vec
  );

  modport master (
    output start, x_in, y_in, z_in,
    input  vec_out, busy, done, pass, err_count, vec_idx, first_fail_vec
  );
endinterface

// File: rtl/gate_vector_checker.sv
// -----------------------------------------------------------------------------
// gate_vector_checker
//   Stimulus/response engine for a multi-input AND/OR/NOR gate block. Each run
//   applies NUM_VECTORS pseudo-random vectors taken from an 8-bit Galois LFSR
//   (mask 8'hB8) and checks the gate outputs against the reductions of the
//   applied vector. One vector takes two cycles: DRIVE presents it, SAMPLE
//   checks it, so the gate path has one full clock to settle.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a run and clears all results
//   bus    gate_vector_checker_if.slave (start, vec_out, x_in/y_in/z_in,
//          busy, done, pass, err_count, vec_idx, first_fail_vec)
//
//   Parameters: N_IN (1..8) gate inputs, NUM_VECTORS (1..255) vectors per run,
//   SEED LFSR load value (8'h00 would lock the LFSR, so it is mapped to 8'h01).
// -----------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int         N_IN        = 4,
  parameter int         NUM_VECTORS = 10,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_vector_checker_if.slave bus
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [7:0]      err_q;
  logic [7:0]      idx_q;
  logic [N_IN-1:0] ffv_q;
  logic            mismatch;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return cur[0] ? ((cur >> 1) ^ 8'hB8) : (cur >> 1);
  endfunction

  // Compared against the registered vector, which has been stable for a
  // whole cycle by the time SAMPLE evaluates it.
  assign mismatch = (bus.x_in != (&vec_q))
                  | (bus.y_in != (|vec_q))
                  | (bus.z_in != (~|vec_q));

  // NOTE: every register, including the result registers, is cleared by the
  // asynchronous reset so that an aborted run leaves no stale results behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      lfsr   <= SEED_EFF;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      idx_q  <= '0;
      ffv_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the pre-edge value of the others (e.g. err_q == 0 below
      // refers to the count before this vector's increment).
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state  <= ST_DRIVE;
            lfsr   <= SEED_EFF;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            idx_q  <= '0;
            ffv_q  <= '0;
          end
        end

        ST_DRIVE: begin
          vec_q <= lfsr[N_IN-1:0];
          lfsr  <= lfsr_next(lfsr);
          state <= ST_SAMPLE;
        end

        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (err_q == 8'd0)  ffv_q <= vec_q;
          end
          if (idx_q == LAST_IDX) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == 8'd0) && !mismatch;
          end else begin
            idx_q <= idx_q + 8'd1;
            state <= ST_DRIVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.vec_idx        = idx_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_vector_checker
//   Directed bench with three checker instances sharing clk/rst_n:
//     u_a : N_IN=4, NUM_VECTORS=10,  SEED=A5, ideal or z=y faulty gate model
//     u_b : N_IN=4, NUM_VECTORS=1,   SEED=00, ideal gate model
//     u_c : N_IN=4, NUM_VECTORS=255, SEED=A5, x inverted
//   Expected values are hand-derived: SEED A5 gives vectors 4'h5 then 4'hA
//   (lfsr A5 -> EA), SEED 00 becomes 01 giving vector 4'h1.
// -----------------------------------------------------------------------------
module tb_gate_vector_checker;

  logic clk;
  logic rst_n;
  logic fault_zy;

  int total;
  int bad;

  gate_vector_checker_if #(.N_IN(4)) if_a ();
  gate_vector_checker_if #(.N_IN(4)) if_b ();
  gate_vector_checker_if #(.N_IN(4)) if_c ();

  gate_vector_checker #(.N_IN(4), .NUM_VECTORS(10), .SEED(8'hA5)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  gate_vector_checker #(.N_IN(4), .NUM_VECTORS(1), .SEED(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );
  gate_vector_checker #(.N_IN(4), .NUM_VECTORS(255), .SEED(8'hA5)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave)
  );

  // Gate block models.
  assign if_a.x_in = &if_a.vec_out;
  assign if_a.y_in = |if_a.vec_out;
  assign if_a.z_in = fault_zy ? (|if_a.vec_out) : (~|if_a.vec_out);

  assign if_b.x_in = &if_b.vec_out;
  assign if_b.y_in = |if_b.vec_out;
  assign if_b.z_in = ~|if_b.vec_out;

  assign if_c.x_in = ~(&if_c.vec_out);
  assign if_c.y_in = |if_c.vec_out;
  assign if_c.z_in = ~|if_c.vec_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},  if_a.vec_out,        0);
    check({tag, "_busy"}, if_a.busy,           0);
    check({tag, "_done"}, if_a.done,           0);
    check({tag, "_pass"}, if_a.pass,           0);
    check({tag, "_err"},  if_a.err_count,      0);
    check({tag, "_idx"},  if_a.vec_idx,        0);
    check({tag, "_ffv"},  if_a.first_fail_vec, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    fault_zy = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    rst_n = 1'b0;
    tick(2);
    check_all_zero("rst");
    rst_n = 1'b1;
    tick(1);

    // Scenario 1: ideal gate, single start pulse.
    if_a.start = 1'b1;
    tick(1);                       // edge 0
    if_a.start = 1'b0;
    check("s1_busy0", if_a.busy, 1);
    tick(1);                       // edge 1
    check("s1_vec0", if_a.vec_out, 4'h5);
    check("s1_idx0", if_a.vec_idx, 0);
    tick(2);                       // edge 3
    check("s1_vec1", if_a.vec_out, 4'hA);
    check("s1_idx1", if_a.vec_idx, 1);
    tick(16);                      // edge 19
    check("s1_done19", if_a.done, 0);
    tick(1);                       // edge 20
    check("s1_done20", if_a.done, 1);
    check("s1_busy20", if_a.busy, 0);
    check("s1_pass", if_a.pass, 1);
    check("s1_err", if_a.err_count, 0);
    check("s1_ffv", if_a.first_fail_vec, 0);
    tick(3);
    check("s1_hold_done", if_a.done, 1);

    // Scenario 2: z tied to y, restart from DONE.
    fault_zy = 1'b1;
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    check("s2_clr_done", if_a.done, 0);
    check("s2_clr_err", if_a.err_count, 0);
    tick(20);
    check("s2_done", if_a.done, 1);
    check("s2_err", if_a.err_count, 10);
    check("s2_pass", if_a.pass, 0);
    check("s2_ffv", if_a.first_fail_vec, 4'h5);
    fault_zy = 1'b0;

    // Scenario 3: reset mid-run, then a clean run.
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    tick(7);
    check("s3_busy_pre", if_a.busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("s3_rst");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    if_a.start = 1'b1;
    tick(1);
    if_a.start = 1'b0;
    tick(1);
    check("s3_vec0", if_a.vec_out, 4'h5);
    tick(19);
    check("s3_done", if_a.done, 1);
    check("s3_pass", if_a.pass, 1);
    check("s3_err", if_a.err_count, 0);

    // Scenario 4: start held high for the whole run.
    if_a.start = 1'b1;
    tick(1);                       // edge 0
    tick(19);                      // edge 19
    check("s4_done19", if_a.done, 0);
    check("s4_busy19", if_a.busy, 1);
    check("s4_idx19", if_a.vec_idx, 9);
    tick(1);                       // edge 20
    check("s4_done20", if_a.done, 1);
    check("s4_busy20", if_a.busy, 0);
    tick(1);                       // edge 21: restart from DONE
    check("s4_rerun_busy", if_a.busy, 1);
    check("s4_rerun_done", if_a.done, 0);
    if_a.start = 1'b0;
    tick(20);
    check("s4_rerun_fin", if_a.done, 1);
    check("s4_rerun_pass", if_a.pass, 1);

    // Scenario 5: one vector, SEED 0 mapped to 1.
    if_b.start = 1'b1;
    tick(1);
    if_b.start = 1'b0;
    check("s5_done0", if_b.done, 0);
    tick(1);
    check("s5_vec0", if_b.vec_out, 4'h1);
    tick(1);
    check("s5_done", if_b.done, 1);
    check("s5_pass", if_b.pass, 1);

    // Scenario 6: 255 vectors, x inverted.
    if_c.start = 1'b1;
    tick(1);
    if_c.start = 1'b0;
    tick(200);
    check("s6_mid_err", if_c.err_count, 100);
    tick(309);
    check("s6_done_pre", if_c.done, 0);
    tick(1);
    check("s6_done", if_c.done, 1);
    check("s6_err", if_c.err_count, 255);
    check("s6_pass", if_c.pass, 0);
    check("s6_ffv", if_c.first_fail_vec, 4'h5);
    tick(2);
    check("s6_err_hold", if_c.err_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
